crossbar_egress_port: RTL and testbench

- Receive side of one crossbar output lane.
- Accepts the crossbar's write-only stream (write strobe, 32-bit ctrl, 480-bit data; no backpressure available upstream) and buffers it.
- Presents the buffered words to the downstream pipeline stage over a valid/ready handshake.
- Filters misrouted words and keeps saturating statistics; one instance sits on each of the four crossbar outputs.

---
 rtl/xbar_pkg.sv | 14 +
 rtl/egress_ram.sv | 18 +
 rtl/crossbar_egress_port.sv | 92 +++++++++
 tb/tb_crossbar_egress_port.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// xbar_pkg: shared crossbar widths, destination field position and egress FSM encoding.
package xbar_pkg;
  localparam int DATA_WIDTH = 480;
  localparam int CTRL_WIDTH = 32;
  localparam int NUM_PORTS = 4;
  localparam int DST_LSB = 0;
  localparam int DST_MSB = 1;
  typedef enum logic {EG_EMPTY = 1'b0, EG_HOLD = 1'b1} eg_state_e;
  function automatic int log2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/egress_ram.sv
// egress_ram: simple dual-port register array, synchronous write, combinational read.
module egress_ram
  import xbar_pkg::*;
#(
  parameter int WIDTH = CTRL_WIDTH + DATA_WIDTH,
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] wr_ptr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_BITS-1:0] rd_ptr,
  output logic [WIDTH-1:0]      rd_data
);
  logic [WIDTH-1:0] mem_q [2**DEPTH_BITS];
  always_ff @(posedge clk) if (we) mem_q[wr_ptr] <= wr_data;
  assign rd_data = mem_q[rd_ptr];
endmodule

// File: rtl/crossbar_egress_port.sv
// crossbar_egress_port: buffers one crossbar output lane, drops misrouted/overflow words,
// and hands words downstream through a registered valid/ready output stage.
module crossbar_egress_port #(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32,
  parameter int PORT_ID = 0,
  parameter int DEPTH_BITS = 4,
  parameter int NEARLY_FULL_MARGIN = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_wr,
  input  logic [CTRL_WIDTH-1:0] in_ctl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [CTRL_WIDTH-1:0] out_ctl,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [DEPTH_BITS:0]   level,
  output logic                  nearly_full,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  misroute_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);
  import xbar_pkg::*;
  localparam logic [DEPTH_BITS:0] DEPTH = {1'b1, {DEPTH_BITS{1'b0}}};
  eg_state_e state_q, state_d;
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0] level_q, level_d;
  logic [CTRL_WIDTH-1:0] out_ctl_q, out_ctl_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d, misroute_cnt_q, misroute_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] head;
  logic routed, push, pop;
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic inc);
    return c + CNT_WIDTH'(inc && !(&c));
  endfunction
  egress_ram #(.WIDTH(CTRL_WIDTH + DATA_WIDTH), .DEPTH_BITS(DEPTH_BITS)) u_ram (
    .clk(clk),
    .we(push),
    .wr_ptr(wr_ptr_q),
    .wr_data({in_ctl, in_data}),
    .rd_ptr(rd_ptr_q),
    .rd_data(head)
  );
  // Fullness is judged on the pre-edge level; a pop on the same edge does not make room.
  always_comb begin
    routed = in_ctl[DST_MSB:DST_LSB] == 2'(PORT_ID);
    push = in_wr && routed && level_q != DEPTH;
    pop = level_q != '0 && (state_q == EG_EMPTY || out_ready);
    state_d = (pop || (state_q == EG_HOLD && !out_ready)) ? EG_HOLD : EG_EMPTY;
    wr_ptr_d = wr_ptr_q + DEPTH_BITS'(push);
    rd_ptr_d = rd_ptr_q + DEPTH_BITS'(pop);
    level_d = level_q + (DEPTH_BITS+1)'(push) - (DEPTH_BITS+1)'(pop);
    {out_ctl_d, out_data_d} = pop ? head : {out_ctl_q, out_data_q};
    drop_cnt_d = sat_inc(drop_cnt_q, in_wr && routed && level_q == DEPTH);
    misroute_cnt_d = sat_inc(misroute_cnt_q, in_wr && !routed);
    pkt_cnt_d = sat_inc(pkt_cnt_q, state_q == EG_HOLD && out_ready);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EG_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      out_ctl_q <= '0;
      out_data_q <= '0;
      drop_cnt_q <= '0;
      misroute_cnt_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      out_ctl_q <= out_ctl_d;
      out_data_q <= out_data_d;
      drop_cnt_q <= drop_cnt_d;
      misroute_cnt_q <= misroute_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
  assign out_valid = state_q == EG_HOLD;
  assign out_ctl = out_ctl_q;
  assign out_data = out_data_q;
  assign level = level_q;
  assign nearly_full = level_q >= DEPTH - (DEPTH_BITS+1)'(NEARLY_FULL_MARGIN);
  assign drop_cnt = drop_cnt_q;
  assign misroute_cnt = misroute_cnt_q;
  assign pkt_cnt = pkt_cnt_q;
endmodule

// File: tb/tb_crossbar_egress_port.sv
// tb_crossbar_egress_port: directed and random stimulus against a queue-based reference model with scoreboard.
module tb_crossbar_egress_port;
  localparam int DW = 480;
  localparam int CW = 32;
  localparam int PID = 2;
  localparam int DB = 4;
  localparam int DEPTH = 1 << DB;
  localparam int NW = 4;
  localparam int CMAX = (1 << NW) - 1;
  logic clk = 0;
  logic rst = 0;
  logic in_wr = 0;
  logic [CW-1:0] in_ctl = '0;
  logic [DW-1:0] in_data = '0;
  logic out_ready = 0;
  logic out_valid, nearly_full;
  logic [CW-1:0] out_ctl;
  logic [DW-1:0] out_data;
  logic [DB:0] level;
  logic [NW-1:0] drop_cnt, misroute_cnt, pkt_cnt;
  int checks = 0;
  int errors = 0;
  logic [CW+DW-1:0] exp_q[$];
  int mlevel = 0, mdrop = 0, mmis = 0, mpkt = 0;
  bit mheld = 0;

  crossbar_egress_port #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .PORT_ID(PID), .DEPTH_BITS(DB),
    .NEARLY_FULL_MARGIN(2), .CNT_WIDTH(NW)
  ) dut (
    .clk(clk), .rst(rst), .in_wr(in_wr), .in_ctl(in_ctl), .in_data(in_data),
    .out_valid(out_valid), .out_ctl(out_ctl), .out_data(out_data), .out_ready(out_ready),
    .level(level), .nearly_full(nearly_full), .drop_cnt(drop_cnt),
    .misroute_cnt(misroute_cnt), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int c);
    return c < CMAX ? c + 1 : c;
  endfunction
  function automatic bit m_acc();
    return in_wr && in_ctl[1:0] == 2'(PID) && mlevel < DEPTH;
  endfunction
  function automatic bit m_load();
    return mlevel > 0 && (!mheld || out_ready);
  endfunction

  // Reference model: words in flight are the scoreboard queue; mheld says whether its front sits in the output stage.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mlevel <= 0;
      mheld <= 0;
      mdrop <= 0;
      mmis <= 0;
      mpkt <= 0;
      exp_q.delete();
    end else begin
      if (in_wr && in_ctl[1:0] != 2'(PID)) mmis <= sat(mmis);
      else if (in_wr && mlevel == DEPTH) mdrop <= sat(mdrop);
      else if (in_wr) exp_q.push_back({in_ctl, in_data});
      if (mheld && out_ready) mpkt <= sat(mpkt);
      mlevel <= mlevel + int'(m_acc()) - int'(m_load());
      mheld <= m_load() || (mheld && !out_ready);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("out_valid", out_valid, mheld);
    chk("level", level, mlevel);
    chk("nearly_full", nearly_full, mlevel >= DEPTH - 2);
    chk("drop_cnt", drop_cnt, mdrop);
    chk("misroute_cnt", misroute_cnt, mmis);
    chk("pkt_cnt", pkt_cnt, mpkt);
    if (mheld && exp_q.size() > 0) begin
      chk("out_ctl", out_ctl, exp_q[0][CW+DW-1:DW]);
      chk("out_data", out_data, exp_q[0][DW-1:0]);
      if (out_ready) void'(exp_q.pop_front());
    end
  end

  task automatic cyc(input logic wr, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    in_wr = wr;
    in_ctl = c;
    in_data = d;
    out_ready = rdy;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_ctl"}, out_ctl, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_nearly_full"}, nearly_full, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
    chk({tag, "_misroute"}, misroute_cnt, 0);
    chk({tag, "_pkt"}, pkt_cnt, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 0;
    in_wr = 0;
    out_ready = 0;
    #1;
    chk_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CW-1:0] c;
    #2;
    chk_zero("por");
    @(posedge clk);
    #1;
    rst = 1;
    cyc(1, 32'h0000_0012, 'hA5, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("basic_valid", out_valid, 1);
    chk("basic_ctl", out_ctl, 32'h12);
    chk("basic_data", out_data, 'hA5);
    chk("basic_level", level, 0);
    cyc(0, 0, 0, 1);
    chk("basic_pkt", pkt_cnt, 1);
    chk("basic_empty", out_valid, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 32'h0000_0031, 480'(i), 1);
    repeat (3) cyc(0, 0, 0, 1);
    chk("mis_cnt", misroute_cnt, 3);
    chk("mis_drop", drop_cnt, 0);
    chk("mis_valid", out_valid, 0);
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1, 32'h0000_0102, 480'(i), 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("bp_level", level, 16);
    chk("bp_nearly_full", nearly_full, 1);
    chk("bp_held_data", out_data, 0);
    for (int i = 0; i < 5; i++) cyc(1, 32'h0000_0202, 480'(100 + i), 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("ovf_drop", drop_cnt, 5);
    chk("ovf_level", level, 16);
    cyc(1, 32'h0000_0302, 480'(999), 1);
    cyc(0, 0, 0, 1);
    chk("sim_drop", drop_cnt, 6);
    chk("sim_level", level, 15);
    chk("sim_data", out_data, 1);
    repeat (20) cyc(0, 0, 0, 1);
    chk("bp_drained_level", level, 0);
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 32'h0000_0003, 480'(i), 1);
    cyc(0, 0, 0, 1);
    chk("sat_misroute", misroute_cnt, 4'hF);
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      c = $urandom;
      if ($urandom_range(3) != 0) c[1:0] = 2'(PID);
      cyc($urandom_range(3) != 0, c, {15{$urandom}},
          (i % 400 < 150) ? ($urandom_range(9) == 0) : ($urandom_range(9) < 7));
      if (i == 1000) begin
        @(posedge clk);
        #3;
        rst = 0;
        #1;
        chk_zero("mid_rst");
        @(posedge clk);
        #1;
        rst = 1;
      end
    end
    repeat (40) cyc(0, 0, 0, 1);
    chk("final_level", level, 0);
    chk("final_valid", out_valid, 0);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
